pipelined_ctrl_unit: RTL and testbench

- Registered successor to the combinational opcode decoder; sits between IF/ID and EX.
- Decodes the 4-bit opcode into the EX/MEM/WB control bundle and holds it in a valid/ready output stage.
- Tracks the EXEC shadow internally across a parametrised number of slots; previously this was a caller-supplied flag.
- Inserts load-use bubbles and honours pipeline flush.

---
 rtl/pipelined_ctrl_unit.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_pipelined_ctrl_unit.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipelined_ctrl_unit
//
// Registered control decoder between IF/ID and EX. A 4-bit opcode is decoded
// into the EX/MEM/WB control bundle. The bundle is held in a single valid/ready
// output stage. The unit also:
//   - suppresses control-flow opcodes that sit in the shadow of an EXEC
//     instruction, counted over EXEC_SHADOW accepted instructions;
//   - inserts LOAD_BUBBLES empty beats when an instruction reads the register
//     written by the load currently held in the output stage;
//   - honours a synchronous pipeline flush.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    instruction handshake from IF/ID
//   in_opcode              4-bit opcode
//   in_rd, in_rs, in_rt    register fields, forwarded with the bundle
//   flush                  kills the staged beat and any pending bubbles
//   out_valid / out_ready  bundle handshake toward EX
//   out_*                  decoded control bundle and forwarded reg fields
//   hazard_stall           high while a load-use bubble is being emitted
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | first cycle after reset release; input is not accepted yet
//   ST_RUN  | normal operation
// -----------------------------------------------------------------------------
module pipelined_ctrl_unit #(
  parameter int RA_W         = 4,
  parameter int EXEC_SHADOW  = 1,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opcode,
  input  logic [RA_W-1:0] in_rd,
  input  logic [RA_W-1:0] in_rs,
  input  logic [RA_W-1:0] in_rt,

  input  logic            flush,

  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_jal,
  output logic            out_jr,
  output logic            out_bran,
  output logic            out_exe,
  output logic            out_raddr_sc,
  output logic            out_waddr_sc,
  output logic            out_bsc,
  output logic            out_immed_sc,
  output logic            out_modify,
  output logic [2:0]      out_alu_op,
  output logic            out_dm_wen,
  output logic            out_rf_wen,
  output logic            out_wdata_sc2,
  output logic [1:0]      out_wdata_sc1,
  output logic [RA_W-1:0] out_rd,
  output logic [RA_W-1:0] out_rs,
  output logic [RA_W-1:0] out_rt,

  output logic            hazard_stall
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic       jal;
    logic       jr;
    logic       bran;
    logic       exe;
    logic       raddr_sc;
    logic       waddr_sc;
    logic       bsc;
    logic       immed_sc;
    logic       modify;
    logic [2:0] alu_op;
    logic       dm_wen;
    logic       rf_wen;
    logic       wdata_sc2;
    logic [1:0] wdata_sc1;
  } ctrl_t;

  localparam logic [3:0] OP_LOAD    = 4'b1000;
  localparam logic [3:0] OP_EXEC    = 4'b1111;
  localparam logic [2:0] EXE_RELOAD = 3'(EXEC_SHADOW);
  // The hazard cycle itself emits the first bubble, so the counter only
  // covers the remaining ones.
  localparam logic [1:0] BUB_RELOAD = (LOAD_BUBBLES > 0) ? 2'(LOAD_BUBBLES - 1) : 2'd0;
  localparam logic       HAZ_EN     = (LOAD_BUBBLES > 0);

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [RA_W-1:0] rs_q, rs_d;
  logic [RA_W-1:0] rt_q, rt_d;
  logic            is_load_q, is_load_d;
  logic [2:0]      exe_cnt_q, exe_cnt_d;
  logic [1:0]      bub_cnt_q, bub_cnt_d;

  ctrl_t dec_ctrl;
  logic  shadowed;
  logic  running;
  logic  stage_free;
  logic  bub_pend;
  logic  hazard;
  logic  accept;
  logic  emit_bub;

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_ctrl = '0;
    shadowed = (exe_cnt_q != 3'd0);
    case (in_opcode[3:2])
      2'b00: begin
        dec_ctrl.raddr_sc = 1'b1;
        dec_ctrl.bsc      = 1'b1;
        dec_ctrl.modify   = 1'b1;
        dec_ctrl.rf_wen   = 1'b1;
        dec_ctrl.alu_op   = in_opcode[2:0];
      end
      2'b01: begin
        dec_ctrl.alu_op = in_opcode[2:0];
        dec_ctrl.rf_wen = 1'b1;
      end
      2'b10: begin
        case (in_opcode[1:0])
          2'b00: begin
            dec_ctrl.rf_wen    = 1'b1;
            dec_ctrl.wdata_sc2 = 1'b1;
          end
          2'b01: dec_ctrl.dm_wen = 1'b1;
          2'b10: begin
            dec_ctrl.immed_sc  = 1'b1;
            dec_ctrl.wdata_sc1 = 2'b10;
            dec_ctrl.rf_wen    = 1'b1;
          end
          default: begin
            dec_ctrl.wdata_sc1 = 2'b10;
            dec_ctrl.rf_wen    = 1'b1;
          end
        endcase
      end
      default: begin
        // Control-flow group: everything stays zero inside the EXEC shadow.
        if (!shadowed) begin
          case (in_opcode[1:0])
            2'b00: dec_ctrl.bran = 1'b1;
            2'b01: begin
              dec_ctrl.jal       = 1'b1;
              dec_ctrl.waddr_sc  = 1'b1;
              dec_ctrl.wdata_sc1 = 2'b11;
              dec_ctrl.rf_wen    = 1'b1;
            end
            2'b10: dec_ctrl.jr = 1'b1;
            default: begin
              dec_ctrl.jr  = 1'b1;
              dec_ctrl.exe = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and hazard detection
  // ---------------------------------------------------------------------------
  assign running    = (state_q == ST_RUN);
  assign stage_free = !out_valid_q || out_ready;
  assign bub_pend   = (bub_cnt_q != 2'd0);
  assign hazard     = HAZ_EN && out_valid_q && is_load_q && in_valid &&
                      ((rd_q == in_rs) || (rd_q == in_rt));

  assign in_ready     = running && stage_free && !bub_pend && !hazard && !flush;
  assign accept       = in_valid && in_ready;
  assign emit_bub     = running && !flush && stage_free && (bub_pend || hazard);
  assign hazard_stall = running && (bub_pend || hazard);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    is_load_d   = is_load_q;
    exe_cnt_d   = exe_cnt_q;
    bub_cnt_d   = bub_cnt_q;

    if (state_q == ST_INIT) begin
      state_d = ST_RUN;
    end

    if (flush) begin
      out_valid_d = 1'b0;
      ctrl_d      = '0;
      rd_d        = '0;
      rs_d        = '0;
      rt_d        = '0;
      is_load_d   = 1'b0;
      exe_cnt_d   = 3'd0;
      bub_cnt_d   = 2'd0;
    end else if (stage_free) begin
      if (emit_bub) begin
        out_valid_d = 1'b1;
        ctrl_d      = '0;
        rd_d        = '0;
        rs_d        = '0;
        rt_d        = '0;
        is_load_d   = 1'b0;
        bub_cnt_d   = bub_pend ? (bub_cnt_q - 2'd1) : BUB_RELOAD;
      end else if (accept) begin
        out_valid_d = 1'b1;
        ctrl_d      = dec_ctrl;
        rd_d        = in_rd;
        rs_d        = in_rs;
        rt_d        = in_rt;
        is_load_d   = (in_opcode == OP_LOAD);
        // A shadowed EXEC only consumes a shadow slot; it never re-arms.
        if ((in_opcode == OP_EXEC) && !shadowed) begin
          exe_cnt_d = EXE_RELOAD;
        end else if (shadowed) begin
          exe_cnt_d = exe_cnt_q - 3'd1;
        end
      end else begin
        // Stage drained with nothing to replace it: keep outputs quiet.
        out_valid_d = 1'b0;
        ctrl_d      = '0;
        rd_d        = '0;
        rs_d        = '0;
        rt_d        = '0;
        is_load_d   = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      is_load_q   <= 1'b0;
      exe_cnt_q   <= 3'd0;
      bub_cnt_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      is_load_q   <= is_load_d;
      exe_cnt_q   <= exe_cnt_d;
      bub_cnt_q   <= bub_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid     = out_valid_q;
  assign out_jal       = ctrl_q.jal;
  assign out_jr        = ctrl_q.jr;
  assign out_bran      = ctrl_q.bran;
  assign out_exe       = ctrl_q.exe;
  assign out_raddr_sc  = ctrl_q.raddr_sc;
  assign out_waddr_sc  = ctrl_q.waddr_sc;
  assign out_bsc       = ctrl_q.bsc;
  assign out_immed_sc  = ctrl_q.immed_sc;
  assign out_modify    = ctrl_q.modify;
  assign out_alu_op    = ctrl_q.alu_op;
  assign out_dm_wen    = ctrl_q.dm_wen;
  assign out_rf_wen    = ctrl_q.rf_wen;
  assign out_wdata_sc2 = ctrl_q.wdata_sc2;
  assign out_wdata_sc1 = ctrl_q.wdata_sc1;
  assign out_rd        = rd_q;
  assign out_rs        = rs_q;
  assign out_rt        = rt_q;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
module tb_pipelined_ctrl_unit;

  localparam int RA_W = 4;
  localparam int EXS  = 2;
  localparam int LB   = 2;
  localparam int NRND = 160;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_opcode = '0;
  logic [RA_W-1:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_jal, out_jr, out_bran, out_exe;
  logic            out_raddr_sc, out_waddr_sc, out_bsc, out_immed_sc, out_modify;
  logic [2:0]      out_alu_op;
  logic            out_dm_wen, out_rf_wen, out_wdata_sc2;
  logic [1:0]      out_wdata_sc1;
  logic [RA_W-1:0] out_rd, out_rs, out_rt;
  logic            hazard_stall;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipelined_ctrl_unit #(.RA_W(RA_W), .EXEC_SHADOW(EXS), .LOAD_BUBBLES(LB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_jal(out_jal), .out_jr(out_jr), .out_bran(out_bran), .out_exe(out_exe),
    .out_raddr_sc(out_raddr_sc), .out_waddr_sc(out_waddr_sc), .out_bsc(out_bsc),
    .out_immed_sc(out_immed_sc), .out_modify(out_modify), .out_alu_op(out_alu_op),
    .out_dm_wen(out_dm_wen), .out_rf_wen(out_rf_wen), .out_wdata_sc2(out_wdata_sc2),
    .out_wdata_sc1(out_wdata_sc1), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .hazard_stall(hazard_stall)
  );

  // Reference decode written straight from the opcode table.
  function automatic logic [16:0] ref_ctrl(input logic [3:0] op, input bit shadowed);
    logic jal, jr, bran, exe, raddr, waddr, bsc, imm, modify, dmw, rfw, wsc2;
    logic [2:0] alu;
    logic [1:0] wsc1;
    {jal, jr, bran, exe, raddr, waddr, bsc, imm, modify, dmw, rfw, wsc2} = '0;
    alu  = 3'd0;
    wsc1 = 2'd0;
    if (op <= 4'd3) begin
      raddr = 1; bsc = 1; modify = 1; rfw = 1; alu = op[2:0];
    end else if (op <= 4'd7) begin
      alu = op[2:0]; rfw = 1;
    end else if (op == 4'd8) begin
      rfw = 1; wsc2 = 1;
    end else if (op == 4'd9) begin
      dmw = 1;
    end else if (op == 4'd10) begin
      imm = 1; wsc1 = 2'b10; rfw = 1;
    end else if (op == 4'd11) begin
      wsc1 = 2'b10; rfw = 1;
    end else if (!shadowed) begin
      if (op == 4'd12) bran = 1;
      else if (op == 4'd13) begin jal = 1; waddr = 1; wsc1 = 2'b11; rfw = 1; end
      else if (op == 4'd14) jr = 1;
      else begin jr = 1; exe = 1; end
    end
    return {jal, jr, bran, exe, raddr, waddr, bsc, imm, modify, alu, dmw, rfw, wsc2, wsc1};
  endfunction

  function automatic logic [28:0] obs();
    return {out_jal, out_jr, out_bran, out_exe, out_raddr_sc, out_waddr_sc, out_bsc,
            out_immed_sc, out_modify, out_alu_op, out_dm_wen, out_rf_wen, out_wdata_sc2,
            out_wdata_sc1, out_rd, out_rs, out_rt};
  endfunction

  task automatic drive(input bit v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt);
    in_valid  = v;
    in_opcode = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || hazard_stall !== 1'b0 || obs() !== '0)
      $display("FAIL reset_outputs: valid=%b ready=%b stall=%b bundle=%h want all 0",
               out_valid, in_ready, hazard_stall, obs());
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL reset_ready_early: got %b want 0", in_ready);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready_return: got %b want 1", in_ready);
    else n_pass++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream();
    logic [3:0] ops [6];
    logic [28:0] e;
    ops = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    out_ready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c < 6) drive(1, ops[c], 4'(c + 1), 4'(c + 8), 4'(c + 9));
      else       drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      if (c < 6) begin
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", c, in_ready);
        else n_pass++;
      end
      if (c > 0) begin
        e = {ref_ctrl(ops[c-1], 0), 4'(c), 4'(c + 7), 4'(c + 8)};
        n_chk++;
        if (out_valid !== 1'b1 || obs() !== e || hazard_stall !== 1'b0)
          $display("FAIL stream_bundle[%0d]: valid=%b stall=%b got %h want %h",
                   c - 1, out_valid, hazard_stall, obs(), e);
        else n_pass++;
      end
      next_cycle();
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain: out_valid=%b want 0", out_valid);
    else n_pass++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_exec_shadow();
    logic [3:0] ops [4];
    bit         sh  [4];
    logic [28:0] e;
    ops = '{4'd15, 4'd12, 4'd13, 4'd0};
    sh  = '{0, 1, 1, 0};
    out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) drive(1, ops[c], 4'(c + 2), 4'(c + 3), 4'(c + 4));
      else       drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      if (c > 0) begin
        e = {ref_ctrl(ops[c-1], sh[c-1]), 4'(c + 1), 4'(c + 2), 4'(c + 3)};
        n_chk++;
        if (out_valid !== 1'b1 || obs() !== e)
          $display("FAIL shadow_bundle[%0d]: valid=%b got %h want %h", c - 1, out_valid, obs(), e);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    logic [28:0] e;
    out_ready = 1'b1;
    drive(1, 4'd8, 4'd3, 4'd0, 4'd0);
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL lu_load_accept: got %b want 1", in_ready);
    else n_pass++;
    next_cycle();
    drive(1, 4'd0, 4'd1, 4'd3, 4'd7);
    @(negedge clk);
    e = {ref_ctrl(4'd8, 0), 4'd3, 4'd0, 4'd0};
    n_chk++;
    if (hazard_stall !== 1'b1 || in_ready !== 1'b0 || obs() !== e)
      $display("FAIL lu_detect: stall=%b ready=%b bundle=%h want stall=1 ready=0 bundle=%h",
               hazard_stall, in_ready, obs(), e);
    else n_pass++;
    next_cycle();
    for (int b = 0; b < LB; b++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || obs() !== '0 || hazard_stall !== (b < LB - 1) ||
          in_ready !== (b == LB - 1))
        $display("FAIL lu_bubble[%0d]: valid=%b bundle=%h stall=%b ready=%b",
                 b, out_valid, obs(), hazard_stall, in_ready);
      else n_pass++;
      next_cycle();
    end
    drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    e = {ref_ctrl(4'd0, 0), 4'd1, 4'd3, 4'd7};
    n_chk++;
    if (out_valid !== 1'b1 || obs() !== e)
      $display("FAIL lu_issue_after: valid=%b got %h want %h", out_valid, obs(), e);
    else n_pass++;
    next_cycle();
    drive(1, 4'd8, 4'd3, 4'd0, 4'd0);
    next_cycle();
    drive(1, 4'd0, 4'd1, 4'd4, 4'd7);
    @(negedge clk);
    n_chk++;
    if (hazard_stall !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL lu_no_dep: stall=%b ready=%b want 0/1", hazard_stall, in_ready);
    else n_pass++;
    next_cycle();
    drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    e = {ref_ctrl(4'd0, 0), 4'd1, 4'd4, 4'd7};
    n_chk++;
    if (out_valid !== 1'b1 || obs() !== e)
      $display("FAIL lu_no_dep_issue: valid=%b got %h want %h", out_valid, obs(), e);
    else n_pass++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [28:0] e;
    out_ready = 1'b1;
    drive(1, 4'd13, 4'd5, 4'd6, 4'd7);
    next_cycle();
    out_ready = 1'b0;
    drive(1, 4'd1, 4'd2, 4'd3, 4'd4);
    e = {ref_ctrl(4'd13, 0), 4'd5, 4'd6, 4'd7};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || obs() !== e || out_jal !== 1'b1 || out_waddr_sc !== 1'b1 ||
          out_wdata_sc1 !== 2'b11 || in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b got %h want %h",
                 k, out_valid, in_ready, obs(), e);
      else n_pass++;
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || obs() !== e)
      $display("FAIL bp_release: ready=%b got %h want ready=1 %h", in_ready, obs(), e);
    else n_pass++;
    next_cycle();
    drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    e = {ref_ctrl(4'd1, 0), 4'd2, 4'd3, 4'd4};
    n_chk++;
    if (out_valid !== 1'b1 || obs() !== e)
      $display("FAIL bp_next_beat: valid=%b got %h want %h", out_valid, obs(), e);
    else n_pass++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    logic [28:0] e;
    out_ready = 1'b1;
    drive(1, 4'd15, 4'd0, 4'd0, 4'd0);
    next_cycle();
    drive(1, 4'd8, 4'd6, 4'd1, 4'd1);
    next_cycle();
    drive(1, 4'd0, 4'd2, 4'd6, 4'd9);
    @(negedge clk);
    n_chk++;
    if (hazard_stall !== 1'b1) $display("FAIL fl_hazard_setup: stall=%b want 1", hazard_stall);
    else n_pass++;
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || obs() !== '0 || in_ready !== 1'b0)
      $display("FAIL fl_first_bubble: valid=%b bundle=%h ready=%b", out_valid, obs(), in_ready);
    else n_pass++;
    next_cycle();
    flush = 1'b0;
    drive(1, 4'd12, 4'd1, 4'd2, 4'd3);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || hazard_stall !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL fl_cleared: valid=%b stall=%b ready=%b want 0/0/1",
               out_valid, hazard_stall, in_ready);
    else n_pass++;
    next_cycle();
    drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    e = {ref_ctrl(4'd12, 0), 4'd1, 4'd2, 4'd3};
    n_chk++;
    if (out_bran !== 1'b1 || obs() !== e)
      $display("FAIL fl_branch_after: bran=%b got %h want %h", out_bran, obs(), e);
    else n_pass++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [28:0] e;
    out_ready = 1'b1;
    drive(1, 4'd15, 4'd0, 4'd0, 4'd0);
    next_cycle();
    drive(1, 4'd8, 4'd2, 4'd0, 4'd0);
    next_cycle();
    drive(1, 4'd0, 4'd1, 4'd2, 4'd5);
    next_cycle();
    #2;
    n_chk++;
    if (out_valid !== 1'b1 || hazard_stall !== 1'b1)
      $display("FAIL ar_mid_bubble: valid=%b stall=%b want 1/1", out_valid, hazard_stall);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || hazard_stall !== 1'b0 || in_ready !== 1'b0 || obs() !== '0)
      $display("FAIL ar_cleared: valid=%b stall=%b ready=%b bundle=%h want all 0",
               out_valid, hazard_stall, in_ready, obs());
    else n_pass++;
    drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    drive(1, 4'd12, 4'd1, 4'd2, 4'd3);
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL ar_ready: got %b want 1", in_ready);
    else n_pass++;
    next_cycle();
    drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    e = {ref_ctrl(4'd12, 0), 4'd1, 4'd2, 4'd3};
    n_chk++;
    if (obs() !== e) $display("FAIL ar_shadow_cleared: got %h want %h", obs(), e);
    else n_pass++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Random stream, offered continuously. Expected beats come from a
  // transaction-level model: a dependent instruction right after a load is
  // preceded by LB empty beats, and control-flow opcodes are zeroed while an
  // EXEC shadow is active.
  task automatic test_random();
    logic [15:0] stim[$];
    logic [28:0] exp_q[$];
    logic [28:0] e;
    logic [3:0]  op, rd, rs, rt, prev_rd;
    int          shadow, idx, cyc;
    bit          prev_load;
    shadow = 0; prev_load = 0; prev_rd = '0;
    for (int i = 0; i < NRND; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 3));
      rs = 4'($urandom_range(0, 3));
      rt = 4'($urandom_range(0, 3));
      stim.push_back({op, rd, rs, rt});
      if (prev_load && (prev_rd == rs || prev_rd == rt))
        for (int b = 0; b < LB; b++) exp_q.push_back('0);
      exp_q.push_back({ref_ctrl(op, shadow != 0), rd, rs, rt});
      if (op == 4'd15 && shadow == 0) shadow = EXS;
      else if (shadow > 0) shadow--;
      prev_load = (op == 4'd8);
      prev_rd   = rd;
    end
    idx = 0; cyc = 0;
    while ((idx < NRND || exp_q.size() > 0) && cyc < 4000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (idx < NRND) drive(1, stim[idx][15:12], stim[idx][11:8], stim[idx][7:4], stim[idx][3:0]);
      else            drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_extra_beat: got %h want no beat", obs());
        end else begin
          e = exp_q.pop_front();
          if (obs() !== e) $display("FAIL rnd_beat: got %h want %h", obs(), e);
          else n_pass++;
        end
      end
      if (in_valid && in_ready === 1'b1) idx++;
      next_cycle();
      cyc++;
    end
    n_chk++;
    if (cyc >= 4000) $display("FAIL rnd_timeout: accepted %0d of %0d, %0d beats pending",
                              idx, NRND, exp_q.size());
    else n_pass++;
    out_ready = 1'b1;
    drive(0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL rnd_drain: out_valid=%b want 0", out_valid);
    else n_pass++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_exec_shadow();
    test_load_use();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
